hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage ARMv8 core.
- Drives write-enables, bubble insertion and flushes for the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards from ID/EX state and freezes the pipeline while data memory is busy.
- Defers branch flushes that arrive during a memory wait; keeps saturating stall/flush event counters.

---
 rtl/hazard_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer for the 5-stage core: load-use bubbles, memory-wait freezes,
// deferred branch flushes, and saturating stall/flush event counters.
module hazard_stall_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [4:0]  ZERO_REG = 5'd31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rd,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             lu_hit, lu, flush_req, flush_evt;

  assign lu_hit = idex_MemRead && (idex_rd != ZERO_REG) &&
                  ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                   (id_use_rs2 && (id_rs2 == idex_rd)));
  assign lu     = lu_hit && (state_q != FLUSH);

  // pending_q can only be set while in MEM_WAIT, so OR-ing it in is harmless elsewhere.
  assign flush_req = branch_taken || pending_q;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    flush_evt   = 1'b0;
    state_d     = state_q;
    pending_d   = pending_q;
    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      state_d     = RUN;
      if (dmem_busy) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        pending_d   = flush_req;
        state_d     = MEM_WAIT;
      end else if (flush_req) begin
        // A flush wins over any load-use stall in the same cycle.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_evt   = 1'b1;
        pending_d   = 1'b0;
        state_d     = FLUSH;
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_d     = LU_STALL;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_write && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
      if (flush_evt && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default-width instance plus a CNT_W=2 instance for saturation.
module tb_hazard_stall_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_use_rs1, id_use_rs2, idex_MemRead, branch_taken, dmem_busy, cnt_clear;

  logic        pc_write, ifid_write, idex_write, exmem_write, idex_bubble;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_write, s_ifid_write, s_idex_write, s_exmem_write, s_idex_bubble;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_count, s_flush_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  hazard_stall_ctrl dut (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_MemRead(idex_MemRead),
    .idex_rd(idex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy), .cnt_clear(cnt_clear),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_stall_ctrl #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_MemRead(idex_MemRead),
    .idex_rd(idex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy), .cnt_clear(cnt_clear),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
    .exmem_write(s_exmem_write), .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .state(s_state),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
      $display("check %-16s got %0d expected %0d ok", tag, obs, exp);
    end else begin
      $display("FAIL %-16s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply inputs away from the edge and let combinational outputs settle.
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic br, input logic busy);
    idex_MemRead = mr; idex_rd = rd; id_rs1 = r1; id_use_rs1 = u1;
    id_rs2 = r2; id_use_rs2 = u2; branch_taken = br; dmem_busy = busy;
    #2;
  endtask

  initial begin
    reset = 1'b0; cnt_clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_pc_write", 32'(pc_write), 0);
    check("rst_exmem_write", 32'(exmem_write), 0);
    check("rst_stall_cnt", 32'(stall_count), 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_writes", 32'({pc_write, ifid_write, idex_write, exmem_write}), 4'b1111);
    check("idle_flush_bub", 32'({idex_bubble, ifid_flush, idex_flush, exmem_flush}), 0);

    // Load-use on rs1
    drive(1, 5, 5, 1, 0, 0, 0, 0);
    check("lu_writes", 32'({pc_write, ifid_write, idex_write, exmem_write}), 4'b0011);
    check("lu_bubble", 32'(idex_bubble), 1);
    tick();
    check("lu_state", 32'(state), 1);
    check("lu_stall_cnt", 32'(stall_count), 1);
    drive(0, 0, 5, 1, 0, 0, 0, 0);
    check("lu_release_pc", 32'(pc_write), 1);
    tick();
    check("lu_back_run", 32'(state), 0);

    // XZR and unused operand never stall
    drive(1, 31, 0, 0, 31, 1, 0, 0);
    check("xzr_pc_write", 32'(pc_write), 1);
    check("xzr_bubble", 32'(idex_bubble), 0);
    drive(1, 7, 0, 0, 7, 0, 0, 0);
    check("unused_pc_write", 32'(pc_write), 1);
    tick();
    check("nostall_state", 32'(state), 0);
    check("nostall_cnt", 32'(stall_count), 1);

    // Branch overrides load-use
    drive(1, 5, 5, 1, 0, 0, 1, 0);
    check("br_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 3'b111);
    check("br_bubble", 32'(idex_bubble), 0);
    check("br_writes", 32'({pc_write, ifid_write, idex_write, exmem_write}), 4'b1111);
    tick();
    check("br_state", 32'(state), 3);
    check("br_flush_cnt", 32'(flush_count), 1);
    drive(1, 5, 5, 1, 0, 0, 0, 0);
    check("flush_lu_masked", 32'(idex_bubble), 0);
    check("flush_lu_pc", 32'(pc_write), 1);
    tick();
    check("flush_to_run", 32'(state), 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("clr_stall_cnt", 32'(stall_count), 0);
    check("clr_flush_cnt", 32'(flush_count), 0);

    // Branch arriving during a memory wait is deferred
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    check("dw_writes", 32'({pc_write, ifid_write, idex_write, exmem_write}), 0);
    check("dw_no_flush", 32'({ifid_flush, idex_flush, exmem_flush}), 0);
    tick();
    check("dw_state1", 32'(state), 2);
    for (int k = 2; k <= 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      check("dw_hold_writes", 32'({pc_write, ifid_write, idex_write, exmem_write}), 0);
      tick();
      check("dw_state", 32'(state), 2);
    end
    check("dw_stall_cnt", 32'(stall_count), 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("dw_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 3'b111);
    check("dw_pc_write", 32'(pc_write), 1);
    tick();
    check("dw_state_flush", 32'(state), 3);
    check("dw_flush_cnt", 32'(flush_count), 1);
    check("dw_stall_final", 32'(stall_count), 3);
    tick();
    check("dw_run", 32'(state), 0);

    // Memory wait ending without pending flush falls into load-use evaluation
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 9, 0, 0, 9, 1, 0, 0);
    check("mw_lu_bubble", 32'(idex_bubble), 1);
    check("mw_lu_flush", 32'(ifid_flush), 0);
    tick();
    check("mw_lu_state", 32'(state), 1);

    // Reset in MEM_WAIT with a pending flush discards it
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    check("rw_state_wait", 32'(state), 2);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    check("rw_state", 32'(state), 0);
    check("rw_pc_write", 32'(pc_write), 0);
    check("rw_exmem_write", 32'(exmem_write), 0);
    check("rw_flush_cnt", 32'(flush_count), 0);
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rw_no_flush", 32'({ifid_flush, idex_flush, exmem_flush}), 0);
    check("rw_pc_after", 32'(pc_write), 1);
    tick();
    check("rw_state_after", 32'(state), 0);
    check("rw_cnt_after", 32'(flush_count), 0);
    check("rw_stall_after", 32'(stall_count), 0);

    // Saturation on the 2-bit instance; the 16-bit one keeps counting
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      check("sat_stall", 32'(s_stall_count), (k > 3) ? 3 : k);
    end
    check("wide_stall", 32'(stall_count), 6);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("sat_clear", 32'(s_stall_count), 0);
    check("wide_clear", 32'(stall_count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
